// File: rtl/vram_arbiter.sv
// ----------------------------------------------------------------------------
// vram_arbiter
//
// Single-port VRAM access scheduler. Three users share one synchronous SRAM:
//   - VGA scanout reads   : absolute priority, never stalled, 2-cycle latency
//   - entity/sprite writes: valid/ready handshake, round-robin with the clear
//   - frame-clear engine  : fills all DEPTH words with one colour
// Every SRAM control signal comes straight from a register, so the SRAM sees
// exactly one clean access per cycle.
//
// Ports
//   clk, w_rst_n                 clock, synchronous active-low reset
//   i_scan_req / i_scan_addr     scanout read request and address
//   o_scan_data / o_scan_valid   read data, valid 2 cycles after the grant
//   i_wr_valid/_addr/_data       entity write request
//   o_wr_ready                   entity write accepted this cycle (comb)
//   i_clear_start/_color         start pulse and fill colour for the clear
//   o_clear_busy / o_clear_done  fill in progress / one-cycle completion pulse
//   o_sram_addr/_we/_data        registered SRAM port
//   i_sram_data                  SRAM registered read data
// ----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 480000
) (
  input  logic                  clk,
  input  logic                  w_rst_n,
  input  logic                  i_scan_req,
  input  logic [ADDR_WIDTH-1:0] i_scan_addr,
  output logic [DATA_WIDTH-1:0] o_scan_data,
  output logic                  o_scan_valid,
  input  logic                  i_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  input  logic                  i_clear_start,
  input  logic [DATA_WIDTH-1:0] i_clear_color,
  output logic                  o_clear_busy,
  output logic                  o_clear_done,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_we,
  output logic [DATA_WIDTH-1:0] o_sram_data,
  input  logic [DATA_WIDTH-1:0] i_sram_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } clr_state_t;

  // Identity of the writer granted most recently; used to break ties.
  typedef enum logic {
    RR_CLEAR  = 1'b0,
    RR_ENTITY = 1'b1
  } rr_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_t            state;
  clr_state_t            state_nxt;
  rr_t                   rr_last;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] clr_color;
  logic                  clear_busy;

  logic                  grant_scan;
  logic                  grant_wr;
  logic                  grant_clr;

  logic                  scan_p1;
  logic [DATA_WIDTH-1:0] scan_hold;

  // --------------------------------------------------------------------------
  // Arbitration (combinational, from the current inputs)
  // --------------------------------------------------------------------------
  // Entity readiness deliberately ignores i_wr_valid so the handshake has no
  // combinational loop through the requester.
  assign o_wr_ready = w_rst_n && !i_scan_req &&
                      (!clear_busy || (rr_last == RR_CLEAR));

  assign grant_scan = i_scan_req;
  assign grant_wr   = i_wr_valid && o_wr_ready;
  assign grant_clr  = !i_scan_req && clear_busy && !grant_wr;

  // --------------------------------------------------------------------------
  // Clear engine FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!w_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Clear engine FSM: next-state logic
  // NOTE: the default assignment first keeps this block free of inferred
  // latches when a branch does not mention state_nxt.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (i_clear_start) state_nxt = S_FILL;
      S_FILL: if (grant_clr && (clr_cnt == LAST_ADDR)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Clear engine FSM: outputs (Moore)
  always_comb begin
    clear_busy   = (state == S_FILL);
    o_clear_done = (state == S_DONE);
  end

  assign o_clear_busy = clear_busy;

  // Fill address counter and latched colour. Start is only honoured in IDLE,
  // so a second pulse during a fill cannot restart it or change the colour.
  always_ff @(posedge clk) begin
    if (!w_rst_n) begin
      clr_cnt   <= '0;
      clr_color <= '0;
    end else if ((state == S_IDLE) && i_clear_start) begin
      clr_cnt   <= '0;
      clr_color <= i_clear_color;
    end else if (grant_clr && (clr_cnt != LAST_ADDR)) begin
      clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
    end
  end

  // Round-robin history: only writer grants move it, scan cycles do not.
  always_ff @(posedge clk) begin
    if (!w_rst_n) begin
      rr_last <= RR_CLEAR;
    end else if (grant_wr) begin
      rr_last <= RR_ENTITY;
    end else if (grant_clr) begin
      rr_last <= RR_CLEAR;
    end
  end

  // --------------------------------------------------------------------------
  // Registered SRAM port. Idle cycles drop WE but hold address and data.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!w_rst_n) begin
      o_sram_addr <= '0;
      o_sram_we   <= 1'b0;
      o_sram_data <= '0;
    end else begin
      o_sram_we <= grant_wr || grant_clr;
      if (grant_scan) begin
        o_sram_addr <= i_scan_addr;
      end else if (grant_wr) begin
        o_sram_addr <= i_wr_addr;
        o_sram_data <= i_wr_data;
      end else if (grant_clr) begin
        o_sram_addr <= clr_cnt;
        o_sram_data <= clr_color;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scan return path. Grant in N -> address on the port in N+1 -> SRAM
  // output register presents the word in N+2, aligned with the second stage
  // of the valid shift. The last valid word is held between reads.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!w_rst_n) begin
      scan_p1      <= 1'b0;
      o_scan_valid <= 1'b0;
      scan_hold    <= '0;
    end else begin
      scan_p1      <= grant_scan;
      o_scan_valid <= scan_p1;
      if (o_scan_valid) begin
        scan_hold <= i_sram_data;
      end
    end
  end

  assign o_scan_data = o_scan_valid ? i_sram_data : scan_hold;

endmodule

// File: tb/tb_vram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vram_arbiter
//
// Directed, self-checking bench for vram_arbiter (DEPTH reduced to 16).
// A small synchronous SRAM model sits on the SRAM port. Expected SRAM writes
// and expected scan read data are pushed into queues when stimulus is driven
// and popped by a monitor when the DUT produces them.
// ----------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk;
  logic          w_rst_n;
  logic          i_scan_req;
  logic [AW-1:0] i_scan_addr;
  logic [DW-1:0] o_scan_data;
  logic          o_scan_valid;
  logic          i_wr_valid;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          o_wr_ready;
  logic          i_clear_start;
  logic [DW-1:0] i_clear_color;
  logic          o_clear_busy;
  logic          o_clear_done;
  logic [AW-1:0] o_sram_addr;
  logic          o_sram_we;
  logic [DW-1:0] o_sram_data;
  logic [DW-1:0] i_sram_data;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic mon_en = 1'b0;

  wr_t           wr_q[$];
  logic [DW-1:0] scan_q[$];
  wr_t           wr_exp;
  logic [DW-1:0] scan_exp;

  vram_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .w_rst_n      (w_rst_n),
    .i_scan_req   (i_scan_req),
    .i_scan_addr  (i_scan_addr),
    .o_scan_data  (o_scan_data),
    .o_scan_valid (o_scan_valid),
    .i_wr_valid   (i_wr_valid),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .o_wr_ready   (o_wr_ready),
    .i_clear_start(i_clear_start),
    .i_clear_color(i_clear_color),
    .o_clear_busy (o_clear_busy),
    .o_clear_done (o_clear_done),
    .o_sram_addr  (o_sram_addr),
    .o_sram_we    (o_sram_we),
    .o_sram_data  (o_sram_data),
    .i_sram_data  (i_sram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM model with registered read output; preloads
  // mem[a] = a & 0xFF on the first clock edge.
  logic [DW-1:0] mem [0:255];
  logic          mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int a = 0; a < 256; a++) mem[a] <= DW'(a);
      mem_loaded <= 1'b1;
    end else if (o_sram_we) begin
      mem[o_sram_addr[7:0]] <= o_sram_data;
    end
    i_sram_data <= mem[o_sram_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int addr, input int data);
    wr_t w;
    w.addr = AW'(addr);
    w.data = DW'(data);
    wr_q.push_back(w);
  endtask

  // Scoreboard monitor: samples on the falling edge, away from updates.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_sram_we) begin
        if (wr_q.size() == 0) begin
          check("wr_unexpected", 32'(o_sram_we), 32'd0);
        end else begin
          wr_exp = wr_q.pop_front();
          check("wr_addr", 32'(o_sram_addr), 32'(wr_exp.addr));
          check("wr_data", 32'(o_sram_data), 32'(wr_exp.data));
        end
      end
      if (o_scan_valid) begin
        if (scan_q.size() == 0) begin
          check("scan_unexpected", 32'(o_scan_valid), 32'd0);
        end else begin
          scan_exp = scan_q.pop_front();
          check("scan_data", 32'(o_scan_data), 32'(scan_exp));
        end
      end
      if (o_clear_done) done_seen++;
    end
  end

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset with every request asserted ----------------
    w_rst_n       = 1'b0;
    i_scan_req    = 1'b1;
    i_scan_addr   = '0;
    i_wr_valid    = 1'b1;
    i_wr_addr     = AW'(7);
    i_wr_data     = 8'hEE;
    i_clear_start = 1'b1;
    i_clear_color = 8'h99;
    repeat (3) step();
    @(negedge clk);
    check("rst_sram_we",    32'(o_sram_we),    32'd0);
    check("rst_sram_addr",  32'(o_sram_addr),  32'd0);
    check("rst_sram_data",  32'(o_sram_data),  32'd0);
    check("rst_scan_valid", 32'(o_scan_valid), 32'd0);
    check("rst_scan_data",  32'(o_scan_data),  32'd0);
    check("rst_clear_busy", 32'(o_clear_busy), 32'd0);
    check("rst_clear_done", 32'(o_clear_done), 32'd0);
    check("rst_wr_ready",   32'(o_wr_ready),   32'd0);

    i_scan_req    = 1'b0;
    i_wr_valid    = 1'b0;
    i_clear_start = 1'b0;
    w_rst_n       = 1'b1;
    step();
    step();
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_wr_ready", 32'(o_wr_ready), 32'd1);
    check("idle_busy",     32'(o_clear_busy), 32'd0);

    // ---------------- scan stream: addresses 0..9 ----------------
    for (int i = 0; i < 14; i++) begin
      step();
      i_scan_req  = (i < 10);
      i_scan_addr = AW'(i);
      if (i < 10) scan_q.push_back(DW'(i));
      @(negedge clk);
      check($sformatf("scan_valid_c%0d", i), 32'(o_scan_valid),
            32'(i >= 2 && i < 12));
    end

    // ---------------- scan priority over entity write ----------------
    for (int i = 0; i < 5; i++) begin
      step();
      i_scan_req  = 1'b1;
      i_scan_addr = AW'(20 + i);
      scan_q.push_back(DW'(20 + i));
      i_wr_valid  = 1'b1;
      i_wr_addr   = AW'(100);
      i_wr_data   = 8'h5A;
      @(negedge clk);
      check($sformatf("prio_ready_c%0d", i), 32'(o_wr_ready), 32'd0);
    end
    step();
    i_scan_req = 1'b0;
    push_wr(100, 8'h5A);
    @(negedge clk);
    check("prio_ready_free", 32'(o_wr_ready), 32'd1);
    check("prio_we_accept_cycle", 32'(o_sram_we), 32'd0);
    step();
    i_wr_valid = 1'b0;
    @(negedge clk);
    check("prio_we_next",   32'(o_sram_we),   32'd1);
    check("prio_addr_next", 32'(o_sram_addr), 32'd100);
    check("prio_data_next", 32'(o_sram_data), 32'h5A);
    // Read back the freshly written pixel through the scan path.
    step();
    i_scan_req  = 1'b1;
    i_scan_addr = AW'(100);
    scan_q.push_back(8'h5A);
    step();
    i_scan_req = 1'b0;
    repeat (3) step();

    // ---------------- full clear, colour 0x3C, restart ignored ----------------
    step();
    i_clear_start = 1'b1;
    i_clear_color = 8'h3C;
    @(negedge clk);
    check("fill_busy_start", 32'(o_clear_busy), 32'd0);
    for (int k = 1; k <= 18; k++) begin
      step();
      i_clear_start = (k == 5);
      i_clear_color = (k == 5) ? 8'hFF : 8'h3C;
      if (k <= 16) push_wr(k - 1, 8'h3C);
      @(negedge clk);
      check($sformatf("fill_busy_c%0d", k), 32'(o_clear_busy), 32'(k <= 16));
      check($sformatf("fill_done_c%0d", k), 32'(o_clear_done), 32'(k == 17));
      if (k == 1) check("fill_ready_rr_entity", 32'(o_wr_ready), 32'd0);
      if (k == 2) check("fill_ready_rr_clear",  32'(o_wr_ready), 32'd1);
    end

    // ---------------- round-robin: entity vs clear ----------------
    step();
    i_clear_start = 1'b1;
    i_clear_color = 8'h11;
    for (int j = 0; j <= 20; j++) begin
      step();
      i_clear_start = 1'b0;
      i_wr_valid    = (j < 8);
      i_wr_addr     = AW'(150 + (j + 1) / 2);
      i_wr_data     = DW'(8'hA0 + (j + 1) / 2);
      if (j < 8) begin
        if (j % 2 == 0) push_wr(150 + j / 2, 8'hA0 + j / 2);
        else            push_wr((j - 1) / 2, 8'h11);
      end else if (j < 20) begin
        push_wr(j - 4, 8'h11);
      end
      @(negedge clk);
      if (j < 8) check($sformatf("rr_ready_c%0d", j), 32'(o_wr_ready),
                       32'(j % 2 == 0));
      check($sformatf("rr_busy_c%0d", j), 32'(o_clear_busy), 32'(j < 20));
      check($sformatf("rr_done_c%0d", j), 32'(o_clear_done), 32'(j == 20));
    end

    // ---------------- reset in the middle of a fill ----------------
    step();
    i_clear_start = 1'b1;
    i_clear_color = 8'h77;
    for (int k = 1; k <= 5; k++) begin
      step();
      i_clear_start = 1'b0;
      push_wr(k - 1, 8'h77);
      @(negedge clk);
      check($sformatf("abort_busy_c%0d", k), 32'(o_clear_busy), 32'd1);
    end
    step();
    w_rst_n    = 1'b0;
    i_wr_valid = 1'b1;
    i_wr_addr  = AW'(60);
    i_wr_data  = 8'hC3;
    @(negedge clk);
    check("abort_ready_in_rst", 32'(o_wr_ready), 32'd0);
    step();
    w_rst_n    = 1'b1;
    i_wr_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_after", 32'(o_clear_busy), 32'd0);
    check("abort_we_after",   32'(o_sram_we),    32'd0);
    check("abort_done_after", 32'(o_clear_done), 32'd0);
    step();
    @(negedge clk);
    check("abort_done_late", 32'(o_clear_done), 32'd0);
    check("abort_done_count", 32'(done_seen), 32'd2);

    // New fill after the abort restarts at address 0.
    step();
    i_clear_start = 1'b1;
    i_clear_color = 8'h42;
    for (int k = 1; k <= 17; k++) begin
      step();
      i_clear_start = 1'b0;
      if (k <= 16) push_wr(k - 1, 8'h42);
      @(negedge clk);
      check($sformatf("refill_done_c%0d", k), 32'(o_clear_done),
            32'(k == 17));
    end
    repeat (3) step();
    @(negedge clk);
    check("final_done_count", 32'(done_seen), 32'd3);
    check("final_wr_q_empty",   32'(wr_q.size()),   32'd0);
    check("final_scan_q_empty", 32'(scan_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
